// File: rtl/dmem_access_unit.sv
// Load/store access stage: decodes execute-stage memory requests to the data BRAM
// or the memory-mapped IO region and returns raw load words to the masking stage.
module dmem_access_unit #(
    parameter int         DMEM_AWIDTH = 14,
    parameter logic [3:0] IO_REGION   = 4'h8,
    parameter int         IO_TIMEOUT  = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [2:0]             req_funct3,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   dmem_en,
    output logic [3:0]             dmem_we,
    output logic [DMEM_AWIDTH-1:0] dmem_addr,
    output logic [31:0]            dmem_din,
    input  logic [31:0]            dmem_dout,
    output logic                   io_req_valid,
    input  logic                   io_ready,
    output logic [31:0]            io_addr,
    output logic                   io_we,
    output logic [3:0]             io_be,
    output logic [31:0]            io_wdata,
    input  logic [31:0]            io_rdata,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_data,
    output logic [2:0]             rsp_load_type,
    output logic [1:0]             rsp_byte_offset,
    output logic                   misaligned,
    output logic                   bus_error
);

    typedef enum logic {RUN, IO_WAIT} state_t;

    localparam int             CW       = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(IO_TIMEOUT - 1);

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic [1:0]      size, off;
    logic            accept, is_io, misal, store_nop, go, dmem_go, io_go;
    logic [3:0]      be;
    logic [31:0]     wdata_rep;
    logic            io_done, io_expire, io_fin_load;
    logic            s1_load;
    logic [2:0]      s1_funct3, io_funct3;
    logic [1:0]      s1_off;
    logic            rsp_from_dmem;
    logic [31:0]     rsp_data_q;

    // Held low during reset so every output reads 0 while rst is asserted.
    assign req_ready = (state == RUN) && !rst;
    assign accept    = req_valid && req_ready;
    assign size      = req_funct3[1:0];
    assign off       = req_addr[1:0];
    assign is_io     = (req_addr[31:28] == IO_REGION);
    assign misal     = ((size == 2'b10) && (off != 2'b00)) || ((size == 2'b01) && off[0]);
    assign store_nop = req_we && (size == 2'b11);
    assign go        = accept && !misal && !store_nop;
    assign dmem_go   = go && !is_io;
    assign io_go     = go && is_io;

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = req_wdata;
        unique case (size)
            2'b00: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << off;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        next_state = state;
        io_done    = 1'b0;
        io_expire  = 1'b0;
        unique case (state)
            RUN: if (io_go) next_state = IO_WAIT;
            IO_WAIT: begin
                // A completion on the expiry cycle takes priority over the timeout.
                if (io_ready) begin
                    io_done    = 1'b1;
                    next_state = RUN;
                end else if (cnt == CNT_LAST) begin
                    io_expire  = 1'b1;
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    assign io_fin_load = (io_done || io_expire) && !io_we;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RUN;
            cnt             <= '0;
            dmem_en         <= 1'b0;
            dmem_we         <= 4'b0000;
            dmem_addr       <= '0;
            dmem_din        <= '0;
            s1_load         <= 1'b0;
            s1_funct3       <= '0;
            s1_off          <= '0;
            io_req_valid    <= 1'b0;
            io_addr         <= '0;
            io_we           <= 1'b0;
            io_be           <= 4'b0000;
            io_wdata        <= '0;
            io_funct3       <= '0;
            rsp_valid       <= 1'b0;
            rsp_from_dmem   <= 1'b0;
            rsp_data_q      <= '0;
            rsp_load_type   <= '0;
            rsp_byte_offset <= '0;
            misaligned      <= 1'b0;
            bus_error       <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= (state == IO_WAIT) ? cnt + 1'b1 : '0;
            misaligned <= accept && misal;
            bus_error  <= io_expire;

            dmem_en <= dmem_go;
            dmem_we <= (dmem_go && req_we) ? be : 4'b0000;
            s1_load <= dmem_go && !req_we;
            if (dmem_go) begin
                dmem_addr <= req_addr[DMEM_AWIDTH+1:2];
                dmem_din  <= wdata_rep;
                s1_funct3 <= req_funct3;
                s1_off    <= off;
            end

            if (io_go) begin
                io_req_valid <= 1'b1;
                io_addr      <= req_addr;
                io_we        <= req_we;
                io_be        <= req_we ? be : 4'b1111;
                io_wdata     <= wdata_rep;
                io_funct3    <= req_funct3;
            end else if (io_done || io_expire) begin
                io_req_valid <= 1'b0;
            end

            // DMEM and IO responses can never land in the same cycle.
            rsp_valid     <= s1_load || io_fin_load;
            rsp_from_dmem <= s1_load;
            if (s1_load) begin
                rsp_load_type   <= s1_funct3;
                rsp_byte_offset <= s1_off;
            end else if (io_fin_load) begin
                rsp_load_type   <= io_funct3;
                rsp_byte_offset <= io_addr[1:0];
                rsp_data_q      <= io_done ? io_rdata : 32'h0;
            end
        end
    end

    // BRAM data arrives one cycle after dmem_en, which is the response cycle itself.
    assign rsp_data = rsp_from_dmem ? dmem_dout : rsp_data_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: BRAM model, scripted IO responder,
// and a response scoreboard filled at request time and drained by a monitor.
module tb_dmem_access_unit;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr, req_wdata;
    logic          dmem_en;
    logic [3:0]    dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_din, dmem_dout;
    logic          io_req_valid, io_ready, io_we;
    logic [31:0]   io_addr, io_wdata, io_rdata;
    logic [3:0]    io_be;
    logic          rsp_valid, misaligned, bus_error;
    logic [31:0]   rsp_data;
    logic [2:0]    rsp_load_type;
    logic [1:0]    rsp_byte_offset;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  lt;
        logic [1:0]  off;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0, n_fail = 0;
    int   n_pushed = 0, n_rsp = 0, n_mis = 0, n_berr = 0;
    bit [31:0] mem [0:(1<<AW)-1];

    dmem_access_unit #(.DMEM_AWIDTH(AW), .IO_REGION(4'h8), .IO_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_din(dmem_din), .dmem_dout(dmem_dout),
        .io_req_valid(io_req_valid), .io_ready(io_ready), .io_addr(io_addr),
        .io_we(io_we), .io_be(io_be), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_load_type(rsp_load_type),
        .rsp_byte_offset(rsp_byte_offset), .misaligned(misaligned), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    // Read-first BRAM with byte write enables.
    always @(posedge clk) begin
        if (dmem_en) begin
            dmem_dout <= mem[dmem_addr];
            for (int b = 0; b < 4; b++)
                if (dmem_we[b]) mem[dmem_addr][8*b +: 8] <= dmem_din[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (misaligned) n_mis++;
            if (bus_error)  n_berr++;
            if (rsp_valid) begin
                n_rsp++;
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_load_type", {29'b0, rsp_load_type}, {29'b0, e.lt});
                    check("rsp_byte_offset", {30'b0, rsp_byte_offset}, {30'b0, e.off});
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic expect_load(input logic [31:0] d, input logic [2:0] lt, input logic [1:0] off);
        exp_t e;
        e.data = d;
        e.lt   = lt;
        e.off  = off;
        sb.push_back(e);
        n_pushed++;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; io_ready = 1'b0; io_rdata = '0;
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_dmem_en", dmem_en, 0);
        check("rst_io_req_valid", io_req_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_flags", {misaligned, bus_error}, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);

        // Back-to-back SW then LW to the same word.
        next_cycle();
        issue(1, 3'b010, 32'h10, 32'hDEADBEEF);
        next_cycle();
        issue(0, 3'b010, 32'h10, 32'h0);
        expect_load(32'hDEADBEEF, 3'b010, 2'b00);
        @(negedge clk);
        check("sw_en", dmem_en, 1);
        check("sw_we", dmem_we, 4'b1111);
        check("sw_addr", dmem_addr, 4);
        check("sw_din", dmem_din, 32'hDEADBEEF);
        next_cycle();
        idle();
        @(negedge clk);
        check("lw_en", dmem_en, 1);
        check("lw_we", dmem_we, 0);
        repeat (3) next_cycle();

        // Byte and halfword stores, then reload the merged word.
        issue(1, 3'b000, 32'h13, 32'h000000AB);
        next_cycle();
        issue(1, 3'b001, 32'h12, 32'h00001234);
        @(negedge clk);
        check("sb_we", dmem_we, 4'b1000);
        check("sb_din", dmem_din, 32'hABABABAB);
        check("sb_addr", dmem_addr, 4);
        next_cycle();
        issue(0, 3'b010, 32'h10, 32'h0);
        expect_load(32'h1234BEEF, 3'b010, 2'b00);
        @(negedge clk);
        check("sh_we", dmem_we, 4'b1100);
        check("sh_din", dmem_din, 32'h12341234);
        next_cycle();
        issue(0, 3'b100, 32'h13, 32'h0);
        expect_load(32'h1234BEEF, 3'b100, 2'b11);
        next_cycle();
        idle();
        repeat (3) next_cycle();

        // Misaligned LW and SH back to back.
        issue(0, 3'b010, 32'h06, 32'h0);
        next_cycle();
        issue(1, 3'b001, 32'h05, 32'hFFFF);
        @(negedge clk);
        check("mis1_flag", misaligned, 1);
        check("mis1_en", dmem_en, 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("mis2_flag", misaligned, 1);
        check("mis2_en", dmem_en, 0);
        next_cycle();
        @(negedge clk);
        check("mis_clear", misaligned, 0);
        repeat (2) next_cycle();

        // IO byte store completing on its first wait cycle.
        issue(1, 3'b000, 32'h80000011, 32'h000000CD);
        next_cycle();
        idle();
        io_ready = 1'b1;
        @(negedge clk);
        check("ios_valid", io_req_valid, 1);
        check("ios_we", io_we, 1);
        check("ios_be", io_be, 4'b0010);
        check("ios_wdata", io_wdata, 32'hCDCDCDCD);
        check("ios_addr", io_addr, 32'h80000011);
        check("ios_ready", req_ready, 0);
        next_cycle();
        io_ready = 1'b0;
        @(negedge clk);
        check("ios_done_valid", io_req_valid, 0);
        check("ios_done_ready", req_ready, 1);
        next_cycle();

        // IO word load, io_ready low for three cycles.
        issue(0, 3'b010, 32'h80000004, 32'h0);
        expect_load(32'h55, 3'b010, 2'b00);
        next_cycle();
        idle();
        @(negedge clk);
        check("iol_valid", io_req_valid, 1);
        check("iol_be", io_be, 4'b1111);
        check("iol_we", io_we, 0);
        check("iol_addr", io_addr, 32'h80000004);
        for (int i = 0; i < 3; i++) begin
            check("iol_ready_low", req_ready, 0);
            next_cycle();
            @(negedge clk);
        end
        check("iol_addr_hold", io_addr, 32'h80000004);
        io_ready = 1'b1;
        io_rdata = 32'h55;
        next_cycle();
        io_ready = 1'b0;
        io_rdata = 32'h0;
        @(negedge clk);
        check("iol_drop", io_req_valid, 0);
        check("iol_ready_back", req_ready, 1);
        check("iol_no_berr", bus_error, 0);
        next_cycle();

        // IO halfword load that times out.
        issue(0, 3'b001, 32'h80000002, 32'h0);
        expect_load(32'h0, 3'b001, 2'b10);
        next_cycle();
        idle();
        repeat (3) next_cycle();
        @(negedge clk);
        check("to_pending", io_req_valid, 1);
        check("to_no_berr_yet", bus_error, 0);
        next_cycle();
        @(negedge clk);
        check("to_berr", bus_error, 1);
        check("to_drop", io_req_valid, 0);
        check("to_ready", req_ready, 1);
        next_cycle();
        @(negedge clk);
        check("to_berr_pulse", bus_error, 0);

        // io_ready coinciding with the expiry cycle wins.
        issue(0, 3'b010, 32'h80000008, 32'h0);
        expect_load(32'h77, 3'b010, 2'b00);
        next_cycle();
        idle();
        repeat (3) next_cycle();
        io_ready = 1'b1;
        io_rdata = 32'h77;
        next_cycle();
        io_ready = 1'b0;
        io_rdata = 32'h0;
        @(negedge clk);
        check("race_no_berr", bus_error, 0);
        check("race_ready", req_ready, 1);
        next_cycle();

        // Reset while waiting on IO discards the transaction.
        issue(0, 3'b010, 32'h80000000, 32'h0);
        next_cycle();
        idle();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rstio_valid", io_req_valid, 0);
        check("rstio_rsp", rsp_valid, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rstio_ready", req_ready, 1);
        check("rstio_idle", io_req_valid, 0);
        issue(0, 3'b010, 32'h10, 32'h0);
        expect_load(32'h1234BEEF, 3'b010, 2'b00);
        next_cycle();
        idle();
        repeat (6) next_cycle();

        check("sb_empty", sb.size(), 0);
        check("rsp_count", n_rsp, n_pushed);
        check("mis_count", n_mis, 2);
        check("berr_count", n_berr, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
